chunked_add_seq: RTL and testbench
==================================

CHUNKED_ADD_SEQ -- requirements
Module: chunked_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, chunk width of the shared adder datapath in bits.
REQ-002 SHALL have parameter CHUNKS, default 4, number of chunks per operand; legal range 1..16.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, request carries a valid operation.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port a, input, WIDTH*CHUNKS, operand A.
REQ-008 SHALL have port b, input, WIDTH*CHUNKS, operand B.
REQ-009 SHALL have port cin, input, 1, carry-in to chunk 0.
REQ-010 SHALL have port out_valid, output, 1, sum/cout hold a completed result.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH*CHUNKS, registered result.
REQ-013 SHALL have port cout, output, 1, registered carry-out of final chunk.
REQ-014 SHALL have port busy, output, 1, high in RUN and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state!=IDLE).
REQ-016 SHALL, in IDLE on in_valid&&in_ready, latch a, b, cin into internal registers, clear chunk index to 0, go to RUN.
REQ-017 SHALL, each RUN cycle, compute {c,s} = a_chunk[idx] + b_chunk[idx] + carry (WIDTH+1-bit result), write s into sum[idx*WIDTH +: WIDTH], carry <= c, idx <= idx+1.
REQ-018 SHALL, on the RUN cycle with idx==CHUNKS-1, write cout <= c and go to DONE.
REQ-019 SHALL assert out_valid exactly CHUNKS rising edges after the accepting edge (latency CHUNKS cycles); one operation per CHUNKS+2 cycles minimum.
REQ-020 SHALL ignore a, b, cin, in_valid while in RUN or DONE; the latched copies alone drive the computation.
REQ-021 SHALL hold sum, cout, out_valid stable in DONE while out_ready is low, for any number of cycles.
REQ-022 SHALL return to IDLE on the edge where out_valid&&out_ready; sum and cout keep their values until overwritten by the next RUN.
REQ-023 SHALL NOT accept a new request in the same cycle a result is consumed (in_ready low in DONE).
REQ-024 SHALL size idx to clog2(CHUNKS) bits minimum 1; CHUNKS=1 SHALL complete in one RUN cycle.
REQ-025 SHALL treat arithmetic as unsigned modulo 2^(WIDTH*CHUNKS), overflow reported only via cout.

Reset
REQ-026 SHALL, on any edge with rst_n low, force state IDLE, idx 0, carry 0, sum 0, cout 0; outputs after that edge: in_ready 1, out_valid 0, busy 0.
REQ-027 SHALL abandon an operation in progress when reset occurs in RUN or DONE; no out_valid SHALL follow for the abandoned operation.
REQ-028 SHALL take reset priority over all handshake events in the same cycle.

Verification
REQ-029 Reset: hold rst_n low 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0; no acceptance.
REQ-030 Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x0000_0000_0000_0001, cin=0, out_ready=1 -> out_valid at 4th edge after accept, sum=0, cout=1, then IDLE next edge.
REQ-031 Per-chunk carry-in: a=0x0001_0002_0003_FFFF, b=0x1000_2000_3000_0000, cin=1 -> sum=0x1001_2002_3004_0000, cout=0.
REQ-032 Backpressure: after result, out_ready=0 for 5 cycles while in_valid=1 with new operands -> sum/cout/out_valid stable, in_ready=0; out_ready=1 -> IDLE, then new request accepted.
REQ-033 Reset mid-operation: drop rst_n for 1 cycle after 2 RUN edges -> IDLE, sum=0, no out_valid; subsequent request 5+7, cin=0 -> sum=12.
REQ-034 CHUNKS=1, WIDTH=16: a=0xFFFF, b=0x0001, cin=1 -> out_valid 1 edge after accept, sum=0x0001, cout=1.

Source files
------------

// File: rtl/chunked_add_seq.sv
// Purpose: multi-word unsigned adder that reuses one WIDTH-bit adder, one chunk per cycle.
// Latency: out_valid rises CHUNKS clock edges after the accepting edge; throughput is one op per CHUNKS+2 cycles.
// Backpressure: result is held in DONE until out_ready; in_ready stays low from acceptance until the result is consumed.
//
// Ports:
//   clk, rst_n             - clock and synchronous active-low reset
//   in_valid / in_ready    - request handshake carrying a, b, cin
//   a, b                   - WIDTH*CHUNKS-bit operands, cin is the carry into chunk 0
//   out_valid / out_ready  - result handshake carrying sum, cout
//   sum, cout              - registered result and carry out of the top chunk
//   busy                   - high while an operation is running or waiting to be consumed
module chunked_add_seq #(
    parameter int WIDTH  = 16,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS-1:0]   sum,
    output logic                      cout,
    output logic                      busy
);

    // A one-chunk configuration still needs a 1-bit index register.
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int TOTAL = WIDTH * CHUNKS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [TOTAL-1:0]   a_q;
    logic [TOTAL-1:0]   b_q;
    logic [TOTAL-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q;
    logic [IDX_W-1:0]   idx_q;

    logic [WIDTH-1:0]   a_chunk;
    logic [WIDTH-1:0]   b_chunk;
    logic [WIDTH:0]     chunk_res;
    logic               accept;
    logic               consume;
    logic               last_chunk;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (consume)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign last_chunk = (state_q == RUN) && (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Chunk select: a constant-index mux keeps the select width exact
    // for any CHUNKS, including non powers of two.
    // ------------------------------------------------------------------
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*WIDTH +: WIDTH];
                b_chunk = b_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Shared adder: WIDTH+1-bit result, top bit is the carry into the next chunk.
    assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{WIDTH{1'b0}}, carry_q};

    // ------------------------------------------------------------------
    // Datapath registers. Operands are captured only on acceptance, so the
    // input buses are free to change while an operation is in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < CHUNKS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum_q[i*WIDTH +: WIDTH] <= chunk_res[WIDTH-1:0];
                end
            end
            carry_q <= chunk_res[WIDTH];
            idx_q   <= idx_q + IDX_W'(1);
            if (last_chunk) begin
                cout_q <= chunk_res[WIDTH];
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Purpose: scoreboard bench for chunked_add_seq (4x16-bit instance plus a 1x16-bit instance).
// Latency: expects out_valid CHUNKS edges after the accepting edge.
// Backpressure: exercises held results with out_ready low and ignored requests in DONE.
module tb_chunked_add_seq;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int TW = W * C;

    logic            clk;
    logic            rst_n;

    // 4-chunk instance
    logic            in_valid;
    logic            in_ready;
    logic [TW-1:0]   a;
    logic [TW-1:0]   b;
    logic            cin;
    logic            out_valid;
    logic            out_ready;
    logic [TW-1:0]   sum;
    logic            cout;
    logic            busy;

    // 1-chunk instance
    logic            in_valid1;
    logic            in_ready1;
    logic [W-1:0]    a1;
    logic [W-1:0]    b1;
    logic            cin1;
    logic            out_valid1;
    logic            out_ready1;
    logic [W-1:0]    sum1;
    logic            cout1;
    logic            busy1;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [TW:0]     exp_q[$];
    logic [W:0]      exp1_q[$];
    int              acc_q[$];
    logic            prev_ov;

    chunked_add_seq #(.WIDTH(W), .CHUNKS(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    chunked_add_seq #(.WIDTH(W), .CHUNKS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [TW:0] act, input logic [TW:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    task automatic fail_now(input string nm);
        checks++;
        $display("FAIL %s timed out", nm);
    endtask

    // Scoreboard monitor for the 4-chunk instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) fail_now("latency_no_accept");
                else chk("latency", TW'(cyc - acc_q.pop_front()), TW'(C + 1));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result actual=%h/%0b required=none", sum, cout);
                end else begin
                    chk("result", {cout, sum}, exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    // Scoreboard monitor for the 1-chunk instance.
    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result1 actual=%h/%0b required=none", sum1, cout1);
            end else begin
                chk("result1", TW'({cout1, sum1}), TW'(exp1_q.pop_front()));
            end
        end
    end

    // All stimulus moves at 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [TW-1:0] ta, input logic [TW-1:0] tb_v, input logic tc,
                         input logic [TW-1:0] es, input logic ec, input bit push);
        int n;
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) fail_now("issue_wait");
        else if (push) exp_q.push_back({ec, es});
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

        // Reset held for two edges with a pending request
        step();
        step();
        chk("rst_in_ready", TW'(in_ready), TW'(1));
        chk("rst_out_valid", TW'(out_valid), TW'(0));
        chk("rst_busy", TW'(busy), TW'(0));
        chk("rst_sum", TW'(sum), TW'(0));
        chk("rst_cout", TW'(cout), TW'(0));
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("rst_no_accept", TW'(busy), TW'(0));

        // Full carry ripple through every chunk
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0, 1'b1, 1);
        wait_out();
        step();
        chk("idle_after_consume", TW'(in_ready), TW'(1));

        // Carry-in into chunk 0 and per-chunk carry propagation
        issue(64'h0001_0002_0003_FFFF, 64'h1000_2000_3000_0000, 1'b1,
              64'h1001_2002_3004_0000, 1'b0, 1);
        wait_out();
        step();

        // Backpressure: result held while new requests are ignored
        out_ready = 1'b0;
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
              64'h2345_6789_ABCD_F001, 1'b0, 1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            a = '1; b = '1; cin = 1'b1; in_valid = 1'b1;
            step();
            chk("bp_out_valid", TW'(out_valid), TW'(1));
            chk("bp_in_ready", TW'(in_ready), TW'(0));
            chk("bp_sum", TW'(sum), TW'(64'h2345_6789_ABCD_F001));
            chk("bp_cout", TW'(cout), TW'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_idle", TW'(in_ready), TW'(1));
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1);
        wait_out();
        step();

        // cin alone, and maximum operands with cin
        issue(64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1);
        wait_out();
        step();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        wait_out();
        step();

        // Reset two RUN edges into an operation
        issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'h0, 1'b0, 0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_in_ready", TW'(in_ready), TW'(1));
        chk("mid_rst_out_valid", TW'(out_valid), TW'(0));
        chk("mid_rst_busy", TW'(busy), TW'(0));
        chk("mid_rst_sum", TW'(sum), TW'(0));
        repeat (6) step();
        chk("abandoned_no_valid", TW'(out_valid), TW'(0));
        issue(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1);
        wait_out();
        step();

        // Single-chunk instance: one RUN cycle
        a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 1'b1; in_valid1 = 1'b1;
        exp1_q.push_back({1'b1, 16'h0001});
        step();
        in_valid1 = 1'b0;
        chk("c1_run_no_valid", TW'(out_valid1), TW'(0));
        step();
        chk("c1_out_valid", TW'(out_valid1), TW'(1));
        chk("c1_sum", TW'(sum1), TW'(16'h0001));
        chk("c1_cout", TW'(cout1), TW'(1));
        step();
        chk("c1_idle", TW'(in_ready1), TW'(1));

        repeat (3) step();
        chk("sb_drained", TW'(exp_q.size()), TW'(0));
        chk("sb1_drained", TW'(exp1_q.size()), TW'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
